// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 IO-mapped UART: register offsets, STATUS bits, FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package j1_io_pkg;

    // Byte offsets of the registers relative to BASE
    localparam logic [15:0] OFF_DATA   = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0002;
    localparam logic [15:0] OFF_DIV    = 16'h0004;

    // STATUS register bit positions
    localparam int ST_TXFULL  = 0;
    localparam int ST_TXBUSY  = 1;
    localparam int ST_RXVALID = 2;
    localparam int ST_TXOVF   = 3;
    localparam int ST_RXOVR   = 4;
    localparam int ST_FERR    = 5;

    // Smallest usable divisor: the RX half-bit delay must be at least one clock
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Divisor writes below DIV_MIN are raised to DIV_MIN
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/j1_uart_fifo.sv
// Synchronous FIFO with first-word fall-through read port, used as the UART TX queue.
// Latency: pushed word visible on pop_data the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module j1_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array is not reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/j1_uart_resp.sv
// IO-mapped 8N1 UART for the J1 CPU: DATA/STATUS/DIV registers, TX FIFO, oversampling-free RX.
// Latency: reads are combinational in the strobe cycle; TX start bit begins one clock after pop.
// Backpressure: none toward the CPU; TX bytes written to a full FIFO are dropped and flagged.
module j1_uart_resp
    import j1_io_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'hF000,
    parameter int          TXDEPTH  = 4,
    parameter logic [15:0] DIV_INIT = 16'd434
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int CW = $clog2(TXDEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TXDEPTH);

    // Word addresses of the three registers
    localparam logic [14:0] W_DATA   = BASE[15:1] + OFF_DATA[15:1];
    localparam logic [14:0] W_STATUS = BASE[15:1] + OFF_STATUS[15:1];
    localparam logic [14:0] W_DIV    = BASE[15:1] + OFF_DIV[15:1];

    // Byte lane bit is irrelevant for 16-bit registers
    logic unused_addr_lsb;
    assign unused_addr_lsb = io_addr[0];

    logic sel_data, sel_status, sel_div;
    logic rd_data, rd_status, rd_div;
    logic wr_data, wr_div;

    assign sel_data   = (io_addr[15:1] == W_DATA);
    assign sel_status = (io_addr[15:1] == W_STATUS);
    assign sel_div    = (io_addr[15:1] == W_DIV);
    assign rd_data    = io_rd & sel_data;
    assign rd_status  = io_rd & sel_status;
    assign rd_div     = io_rd & sel_div;
    assign wr_data    = io_wr & sel_data;
    assign wr_div     = io_wr & sel_div;

    logic [15:0] div_q;

    // TX datapath
    tx_state_t      tx_state;
    logic [15:0]    tx_cnt;
    logic [15:0]    tx_div;
    logic [2:0]     tx_bits;
    logic [7:0]     tx_shift;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           tx_busy;
    logic           tx_full;
    logic           txovf_set;

    // RX datapath
    rx_state_t      rx_state;
    logic           rx_s1, rx_s2, rx_prev;
    logic [15:0]    rx_cnt;
    logic [15:0]    rx_div;
    logic [2:0]     rx_bits;
    logic [7:0]     rx_shift;
    logic           rx_stop_hit;
    logic           byte_good;
    logic           ferr_set;
    logic           rxovr_set;
    logic [7:0]     rx_byte;
    logic           rx_valid;

    // Sticky error flags
    logic           ferr, rxovr, txovf;
    logic [15:0]    status_word;

    assign fifo_pop  = (tx_state == TX_IDLE) & ~fifo_empty;
    assign tx_busy   = (tx_state != TX_IDLE) | ~fifo_empty;
    assign tx_full   = (fifo_count == FULL_CNT);
    // Overflow only when the byte is really dropped, not when the FSM frees a slot this cycle
    assign txovf_set = wr_data & fifo_full & ~fifo_pop;

    j1_uart_fifo #(
        .DEPTH (TXDEPTH),
        .WIDTH (8)
    ) u_txfifo (
        .clk       (sys_clk_i),
        .rst       (sys_rst_i),
        .push      (wr_data),
        .push_data (io_dout[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Baud divisor register, clamped on write
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            div_q <= DIV_INIT;
        end else if (wr_div) begin
            div_q <= clamp_div(io_dout);
        end
    end

    // TX FSM: the divisor is latched at the start bit so a DIV write never tears a frame
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= DIV_INIT;
            tx_bits  <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        tx_shift <= fifo_dout;
                        tx_div   <= div_q;
                        tx_cnt   <= div_q - 16'd1;
                        uart_tx  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == 16'd0) begin
                        uart_tx  <= tx_shift[0];
                        tx_cnt   <= tx_div - 16'd1;
                        tx_bits  <= '0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= tx_div - 16'd1;
                        if (tx_bits == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            uart_tx  <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                            tx_bits  <= tx_bits + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX FSM: first sample half a bit after the edge, then one sample per bit period
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_INIT;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_div   <= div_q;
                        rx_cnt   <= (div_q >> 1) - 16'd1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_cnt   <= rx_div - 16'd1;
                            rx_bits  <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= rx_div - 16'd1;
                        rx_bits  <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_stop_hit = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
    assign byte_good   = rx_stop_hit & rx_s2;
    assign ferr_set    = rx_stop_hit & ~rx_s2;
    // A byte landing while the CPU reads the old one loses nothing, so it is not an overrun
    assign rxovr_set   = byte_good & rx_valid & ~rd_data;

    // Receive holding register; a newly arrived byte beats a concurrent DATA read
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else if (byte_good) begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
        end else if (rd_data) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky flags: cleared by a STATUS read unless set again on the same edge
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ferr  <= 1'b0;
            rxovr <= 1'b0;
            txovf <= 1'b0;
        end else begin
            ferr  <= (ferr  & ~rd_status) | ferr_set;
            rxovr <= (rxovr & ~rd_status) | rxovr_set;
            txovf <= (txovf & ~rd_status) | txovf_set;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_word             = '0;
        status_word[ST_TXFULL]  = tx_full;
        status_word[ST_TXBUSY]  = tx_busy;
        status_word[ST_RXVALID] = rx_valid;
        status_word[ST_TXOVF]   = txovf;
        status_word[ST_RXOVR]   = rxovr;
        status_word[ST_FERR]    = ferr;
    end

    // Read mux; zero when not addressed so several peripherals can be OR-ed together
    always_comb begin
        io_din = 16'h0000;
        if (rd_data)        io_din = {rx_valid, 7'b0, rx_byte};
        else if (rd_status) io_din = status_word;
        else if (rd_div)    io_din = div_q;
    end

endmodule

// File: tb/tb_j1_uart_resp.sv
// Self-checking bench for j1_uart_resp: register table, TX/RX frame scenarios, random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_j1_uart_resp;

    localparam logic [15:0] BASE = 16'hF000;
    localparam int          DIVB = 4;
    localparam logic [15:0] A_DATA   = BASE;
    localparam logic [15:0] A_STATUS = BASE + 16'h2;
    localparam logic [15:0] A_DIV    = BASE + 16'h4;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i = 1'b1;
    logic        io_rd     = 1'b0;
    logic        io_wr     = 1'b0;
    logic [15:0] io_addr   = 16'h0000;
    logic [15:0] io_dout   = 16'h0000;
    logic [15:0] io_din;
    logic        uart_tx;
    logic        uart_rx   = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    // Frames decoded from uart_tx: bit 8 flags a bad start/stop bit
    logic [8:0] txq[$];

    always #5 sys_clk_i = ~sys_clk_i;

    j1_uart_resp #(
        .BASE     (BASE),
        .TXDEPTH  (4),
        .DIV_INIT (16'd434)
    ) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_din    (io_din),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge sys_clk_i);
        io_addr = a;
        io_dout = d;
        io_wr   = 1'b1;
        @(posedge sys_clk_i);
        #1 io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge sys_clk_i);
        io_addr = a;
        io_rd   = 1'b1;
        #1 d = io_din;
        @(posedge sys_clk_i);
        #1 io_rd = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        io_read(a, d);
        check(name, {48'h0, d}, {48'h0, exp});
    endtask

    // Drive one 8N1 frame at DIVB clocks per bit, then leave the line idle briefly
    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk_i);
            uart_rx = fr[i];
            repeat (DIVB - 1) @(negedge sys_clk_i);
        end
        @(negedge sys_clk_i);
        uart_rx = 1'b1;
        repeat (4) @(negedge sys_clk_i);
    endtask

    task automatic wait_tx_low(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk_i);
            n++;
        end while (uart_tx !== 1'b0 && n < budget);
        check(name, {63'h0, uart_tx}, 64'h0);
    endtask

    task automatic wait_txq(input string name, input int cnt, input int budget);
        int n;
        n = 0;
        while (txq.size() < cnt && n < budget) begin
            @(negedge sys_clk_i);
            n++;
        end
        check(name, txq.size(), cnt);
    endtask

    // Frame monitor: samples the middle of each bit, fixed at DIVB
    initial begin : tx_monitor
        logic [7:0] mb;
        logic       bad;
        forever begin
            @(negedge sys_clk_i);
            if (uart_tx === 1'b0) begin
                bad = 1'b0;
                repeat (DIVB / 2) @(negedge sys_clk_i);
                if (uart_tx !== 1'b0) bad = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    repeat (DIVB) @(negedge sys_clk_i);
                    mb[k] = uart_tx;
                end
                repeat (DIVB) @(negedge sys_clk_i);
                if (uart_tx !== 1'b1) bad = 1'b1;
                txq.push_back({bad, mb});
            end
        end
    end

    typedef struct {
        logic        do_wr;
        logic [15:0] waddr;
        logic [15:0] wdat;
        logic [15:0] raddr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin : main
        logic [15:0] d;
        logic [39:0] cap;
        logic [39:0] exp_wave;
        logic [9:0]  fr;
        logic [7:0]  ovf_bytes[6];
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        logic [7:0]  last_b;
        int          nb;

        tbl[0]  = '{1'b1, A_DIV,          16'h0000, A_DIV,          16'h0002};
        tbl[1]  = '{1'b1, A_DIV,          16'h0001, A_DIV,          16'h0002};
        tbl[2]  = '{1'b1, A_DIV,          16'h0003, A_DIV,          16'h0003};
        tbl[3]  = '{1'b1, A_DIV,          16'hBEEF, A_DIV,          16'hBEEF};
        tbl[4]  = '{1'b0, 16'h0000,       16'h0000, BASE + 16'h5,   16'hBEEF};
        tbl[5]  = '{1'b0, 16'h0000,       16'h0000, A_DATA,         16'h0000};
        tbl[6]  = '{1'b1, BASE + 16'h10,  16'h00F0, A_STATUS,       16'h0000};
        tbl[7]  = '{1'b1, 16'h0100,       16'h00AA, A_STATUS,       16'h0000};
        tbl[8]  = '{1'b1, BASE + 16'h10,  16'h1234, BASE + 16'h10,  16'h0000};
        tbl[9]  = '{1'b0, 16'h0000,       16'h0000, 16'h0100,       16'h0000};
        tbl[10] = '{1'b0, 16'h0000,       16'h0000, BASE + 16'h6,   16'h0000};
        tbl[11] = '{1'b1, A_DIV,          16'h0004, A_DIV,          16'h0004};

        // Reset: values visible while reset is still held
        repeat (3) @(posedge sys_clk_i);
        read_check("rst_hold_div", A_DIV, 16'd434);
        read_check("rst_hold_status", A_STATUS, 16'h0000);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        check("rst_uart_tx", {63'h0, uart_tx}, 64'h1);
        read_check("rst_status", A_STATUS, 16'h0000);
        read_check("rst_data", A_DATA, 16'h0000);
        read_check("rst_div", A_DIV, 16'd434);
        @(negedge sys_clk_i);
        io_addr = A_DIV;
        #1 check("din_no_rd", {48'h0, io_din}, 64'h0);

        // Register table
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_wr) io_write(tbl[i].waddr, tbl[i].wdat);
            read_check($sformatf("tbl[%0d]", i), tbl[i].raddr, tbl[i].exp);
        end

        // Exact waveform of 0x55 at DIV=4
        txq.delete();
        io_write(A_DATA, 16'h0055);
        wait_tx_low("tx55_start", 20);
        cap[0] = uart_tx;
        for (int k = 1; k < 40; k++) begin
            @(negedge sys_clk_i);
            cap[k] = uart_tx;
        end
        fr = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 40; k++) exp_wave[k] = fr[k / 4];
        check("tx55_wave", {24'h0, cap}, {24'h0, exp_wave});
        read_check("tx55_idle_status", A_STATUS, 16'h0000);
        wait_txq("tx55_mon_cnt", 1, 20);
        if (txq.size() > 0) check("tx55_mon_byte", {55'h0, txq.pop_front()}, {55'h0, 9'h055});

        // Fill the FIFO while idle, then overflow it
        txq.delete();
        ovf_bytes[0] = 8'hC1; ovf_bytes[1] = 8'h52; ovf_bytes[2] = 8'h03;
        ovf_bytes[3] = 8'hE4; ovf_bytes[4] = 8'h75; ovf_bytes[5] = 8'h99;
        for (int i = 0; i < 6; i++) io_write(A_DATA, {8'h00, ovf_bytes[i]});
        read_check("ovf_status1", A_STATUS, 16'h000B);
        read_check("ovf_status2", A_STATUS, 16'h0003);
        wait_txq("ovf_mon_cnt", 5, 5 * 40 + 60);
        for (int i = 0; i < 5; i++) begin
            if (txq.size() > 0)
                check($sformatf("ovf_byte%0d", i), {55'h0, txq.pop_front()}, {55'h0, 1'b0, ovf_bytes[i]});
        end
        repeat (4) @(negedge sys_clk_i);
        check("ovf_dropped", txq.size(), 0);
        read_check("ovf_idle_status", A_STATUS, 16'h0000);

        // Receive path
        rx_send(8'hA3, 1'b1);
        read_check("rx_a3_status", A_STATUS, 16'h0004);
        read_check("rx_a3_data1", A_DATA, 16'h80A3);
        read_check("rx_a3_data2", A_DATA, 16'h00A3);
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        read_check("rx_ovr_status", A_STATUS, 16'h0014);
        read_check("rx_ovr_data", A_DATA, 16'h8022);
        read_check("rx_ovr_clear", A_STATUS, 16'h0000);
        rx_send(8'h5A, 1'b0);
        read_check("rx_ferr_status", A_STATUS, 16'h0020);
        read_check("rx_ferr_clear", A_STATUS, 16'h0000);
        read_check("rx_ferr_data", A_DATA, 16'h0022);

        // Random traffic against a byte-queue model
        for (int it = 0; it < 6; it++) begin
            txq.delete();
            exp_q.delete();
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                io_write(A_DATA, {8'h00, b});
            end
            wait_txq($sformatf("rnd%0d_tx_cnt", it), nb, nb * 40 + 60);
            for (int j = 0; j < nb; j++) begin
                if (txq.size() > 0 && exp_q.size() > 0)
                    check($sformatf("rnd%0d_tx%0d", it, j), {55'h0, txq.pop_front()},
                          {55'h0, 1'b0, exp_q.pop_front()});
            end
            nb = $urandom_range(1, 2);
            last_b = 8'h00;
            for (int j = 0; j < nb; j++) begin
                last_b = 8'($urandom_range(0, 255));
                rx_send(last_b, 1'b1);
            end
            read_check($sformatf("rnd%0d_rx_status", it), A_STATUS, (nb > 1) ? 16'h0014 : 16'h0004);
            read_check($sformatf("rnd%0d_rx_data", it), A_DATA, {8'h80, last_b});
        end

        // Reset in the middle of data bit 3 of a frame
        io_write(A_DATA, 16'h00F7);
        wait_tx_low("rst_tx_start", 20);
        repeat (4 * DIVB + DIVB / 2) @(negedge sys_clk_i);
        check("rst_tx_bit3", {63'h0, uart_tx}, 64'h0);
        sys_rst_i = 1'b1;
        @(posedge sys_clk_i);
        #1 check("rst_tx_high", {63'h0, uart_tx}, 64'h1);
        read_check("rst_mid_div", A_DIV, 16'd434);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        read_check("rst_mid_status", A_STATUS, 16'h0000);
        read_check("rst_mid_div2", A_DIV, 16'd434);
        repeat (20) @(negedge sys_clk_i);
        check("rst_tx_stays_high", {63'h0, uart_tx}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
